// File: rtl/vc_flow_pkg.sv
// vc_flow_pkg: shared state encoding and default widths for the VC FIFO flow-control blocks
package vc_flow_pkg;
  typedef enum logic [1:0] {INIT = 2'b00, IDLE = 2'b01, ACTIVE = 2'b10} state_t;
  localparam int DATA_WIDTH_DEF = 6;
  localparam int ADDR_WIDTH_DEF = 4;
endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: dual-port register array, synchronous write, synchronous registered read
// ports: clk, rst (async, clears read register only), we/wr_addr/wr_data write port,
//        re/rd_addr read port, rd_data read register (holds when re=0)
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  // a read and write to the same slot in one cycle returns the old word
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
endmodule

// File: rtl/vc_fifo_flow.sv
// vc_fifo_flow: per-VC FIFO with registered pause/almost_empty flow-control flags
// ports: clk, reset (async high), init (flush + load thresholds), umbral_alto/umbral_bajo
//        thresholds, push/data_in write, pop read, data_out/valid_out registered read data,
//        full/empty from count, pause/almost_empty registered flags, error illegal-access pulse
module vc_fifo_flow
  import vc_flow_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  pause,
  output logic                  almost_empty,
  output logic                  error
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t state, state_next;
  logic [ADDR_WIDTH-1:0] rd_ptr, wr_ptr;
  logic [ADDR_WIDTH:0] count, count_next, thr_alto, thr_bajo;
  logic op, push_acc, pop_acc, err_next;
  assign full = count == DEPTH;
  assign empty = count == '0;
  // the cycle that leaves INIT still ignores traffic; accesses start once in IDLE/ACTIVE
  always_comb begin
    op = !init && state != INIT;
    pop_acc = op && pop && !empty;
    push_acc = op && push && (!full || pop);
    err_next = op && ((push && full && !pop) || (pop && empty));
    count_next = init ? '0 : count + (ADDR_WIDTH+1)'(push_acc) - (ADDR_WIDTH+1)'(pop_acc);
    state_next = init ? INIT : (count_next == '0 ? IDLE : ACTIVE);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= INIT;
    else state <= state_next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      thr_alto <= DEPTH;
      thr_bajo <= '0;
      valid_out <= 1'b0;
      error <= 1'b0;
      pause <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (init) begin
        thr_alto <= umbral_alto;
        thr_bajo <= umbral_bajo;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(pop_acc);
        wr_ptr <= wr_ptr + ADDR_WIDTH'(push_acc);
      end
      count <= count_next;
      valid_out <= pop_acc;
      error <= err_next;
      pause <= !init && count_next >= thr_alto;
      almost_empty <= init || count_next <= thr_bajo;
    end
  fifo_mem_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk(clk),
    .rst(reset),
    .we(push_acc),
    .wr_addr(wr_ptr),
    .wr_data(data_in),
    .re(pop_acc),
    .rd_addr(rd_ptr),
    .rd_data(data_out)
  );
endmodule

// File: tb/tb_vc_fifo_flow.sv
// tb_vc_fifo_flow: directed + randomized check of vc_fifo_flow against a queue-based model
module tb_vc_fifo_flow;
  logic clk = 1'b0;
  logic reset, init, push, pop;
  logic [5:0] data_in, data_out;
  logic [4:0] umbral_alto, umbral_bajo;
  logic valid_out, full, empty, pause, almost_empty, error;
  int n_cmp = 0, n_err = 0;
  logic [5:0] q[$];
  int tha, thb;
  bit m_init, m_valid, m_err, m_pause, m_ae;
  logic [5:0] m_data;
  always #5 clk = ~clk;
  vc_fifo_flow dut (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out), .valid_out(valid_out),
    .full(full), .empty(empty), .pause(pause), .almost_empty(almost_empty), .error(error)
  );
  function void mreset();
    q.delete();
    tha = 16;
    thb = 0;
    m_init = 1;
    m_data = '0;
    m_valid = 0;
    m_err = 0;
    m_pause = 0;
    m_ae = 1;
  endfunction
  task chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task check_all(string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    chk({tag, ".valid_out"}, 32'(valid_out), 32'(m_valid));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 16));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".pause"}, 32'(pause), 32'(m_pause));
    chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_ae));
    chk({tag, ".error"}, 32'(error), 32'(m_err));
  endtask
  task step(string tag, bit i, bit ps, bit pp, logic [5:0] d, logic [4:0] ua, logic [4:0] ub);
    bit do_pop, do_push;
    init = i;
    push = ps;
    pop = pp;
    data_in = d;
    umbral_alto = ua;
    umbral_bajo = ub;
    @(posedge clk);
    #1;
    if (i) begin
      q.delete();
      tha = int'(ua);
      thb = int'(ub);
      m_init = 1;
      m_valid = 0;
      m_err = 0;
      m_pause = 0;
      m_ae = 1;
    end else begin
      do_pop = 0;
      do_push = 0;
      m_err = 0;
      if (!m_init) begin
        if (pp) begin
          if (q.size() == 0) m_err = 1;
          else do_pop = 1;
        end
        if (ps) begin
          if (q.size() == 16 && !pp) m_err = 1;
          else do_push = 1;
        end
      end
      m_valid = do_pop;
      if (do_pop) m_data = q.pop_front();
      if (do_push) q.push_back(d);
      m_init = 0;
      m_pause = q.size() >= tha;
      m_ae = q.size() <= thb;
    end
    check_all(tag);
  endtask
  task do_reset();
    #2;
    reset = 1'b1;
    #1;
    mreset();
    check_all("async_reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    init = 0;
    push = 0;
    pop = 0;
    data_in = '0;
    umbral_alto = '0;
    umbral_bajo = '0;
    repeat (2) @(posedge clk);
    #1;
    mreset();
    check_all("reset");
    reset = 1'b0;
    // 1: init load, some traffic, then reset mid-traffic and reload
    repeat (2) step("init", 1, 0, 0, 0, 12, 2);
    step("leave_init", 0, 1, 1, 6'h3F, 12, 2);
    for (int k = 0; k < 5; k++) step("pre_traffic", 0, 1, k[0], 6'(k + 7), 12, 2);
    do_reset();
    repeat (2) step("init2", 1, 1, 1, 0, 12, 2);
    step("idle", 0, 0, 0, 0, 12, 2);
    // 2: fill to pause and full, then overflow
    for (int k = 1; k <= 16; k++) step("fill", 0, 1, 0, 6'(k), 12, 2);
    step("overflow", 0, 1, 0, 6'h3E, 12, 2);
    step("after_overflow", 0, 0, 0, 0, 12, 2);
    // 3: drain in order, then underflow
    for (int k = 1; k <= 16; k++) step("drain", 0, 0, 1, 0, 12, 2);
    step("underflow", 0, 0, 1, 0, 12, 2);
    step("after_underflow", 0, 0, 0, 0, 12, 2);
    // 4: simultaneous push/pop at full and at empty
    for (int k = 0; k < 16; k++) step("refill", 0, 1, 0, 6'(8'h20 + k), 12, 2);
    step("full_pushpop", 0, 1, 1, 6'h15, 12, 2);
    for (int k = 0; k < 16; k++) step("drain2", 0, 0, 1, 0, 12, 2);
    step("empty_pushpop", 0, 1, 1, 6'h33, 12, 2);
    step("pop_last", 0, 0, 1, 0, 12, 2);
    // 5: pointer wrap-around
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 10; k++) step("wrap_push", 0, 1, 0, 6'(r * 10 + k), 12, 2);
      for (int k = 0; k < 10; k++) step("wrap_pop", 0, 0, 1, 0, 12, 2);
    end
    step("wrap_push2a", 0, 1, 0, 6'h2A, 12, 2);
    step("wrap_pop2a", 0, 0, 1, 0, 12, 2);
    step("wrap_idle", 0, 0, 0, 0, 12, 2);
    // 6: init flush with a new almost-full level
    for (int k = 0; k < 7; k++) step("pre_flush", 0, 1, 0, 6'(k + 40), 12, 2);
    step("flush", 1, 1, 1, 6'h11, 4, 2);
    step("flush_exit", 0, 1, 1, 6'h12, 4, 2);
    for (int k = 0; k < 4; k++) step("pause4", 0, 1, 0, 6'(k + 50), 4, 2);
    step("pause4_idle", 0, 0, 0, 0, 4, 2);
    // randomized traffic with occasional re-init, including out-of-range thresholds
    for (int k = 0; k < 1200; k++) begin
      int bias;
      bias = ((k / 100) % 2 == 1) ? 75 : 25;
      if ($urandom_range(0, 79) == 0)
        step("rnd_init", 1, 0, 0, 0, 5'($urandom_range(0, 20)), 5'($urandom_range(0, 17)));
      else
        step("rnd", 0, $urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias,
             6'($urandom), 5'($urandom), 5'($urandom));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/vc_fifo_flow.md
Name: vc_fifo_flow

Overview:
Virtual-channel FIFO with registered flow-control outputs. It sits between the main-FIFO pop path and the output demux, one instance per VC. It buffers words pushed by the upstream pop logic and raises `pause` when occupancy reaches a programmable almost-full level. Upstream input-flow logic ORs the `pause` of both VC instances to stop popping the main FIFO.

Parameters:
- DATA_WIDTH, 6, width of a stored word.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH = 16.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- init  input  1  high = enter INIT state, flush contents, load thresholds.
- umbral_alto  input  ADDR_WIDTH+1  almost-full threshold; sampled only in INIT.
- umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold; sampled only in INIT.
- push  input  1  write data_in this cycle.
- data_in  input  DATA_WIDTH  word to write.
- pop  input  1  read one word this cycle.
- data_out  output  DATA_WIDTH  registered read data.
- valid_out  output  1  data_out holds a word popped in the previous cycle.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- pause  output  1  registered; count >= thr_alto.
- almost_empty  output  1  registered; count <= thr_bajo.
- error  output  1  one-cycle pulse on an illegal access.

Behaviour:
- **Reset:**
  - Asynchronous, active-high; takes effect immediately, even mid-operation.
  - On reset: state=INIT, rd_ptr=wr_ptr=0, count=0, data_out=0, valid_out=0, error=0, pause=0.
  - Also on reset: thr_alto=depth, thr_bajo=0, empty=1, almost_empty=1, full=0.
  - Stored memory contents are don't-care.
- **States:** INIT, IDLE (count==0), ACTIVE (count>0).
  - INIT: each cycle with init=1, latch thr_alto<=umbral_alto and thr_bajo<=umbral_bajo, and force pointers and count to 0. Push and pop are ignored, with no error.
  - INIT -> IDLE on the first cycle init=0.
  - Any state -> INIT when init=1; the FIFO is flushed.
  - IDLE -> ACTIVE on an accepted push.
  - ACTIVE -> IDLE when count reaches 0.
- **Accepted operations (IDLE/ACTIVE only):**
  - Push accepted if !full, or if full and pop is asserted in the same cycle.
  - Pop accepted if !empty. Pop and push in the same cycle when empty: push accepted, pop rejected; there is no bypass.
  - count_next = count + push_acc - pop_acc, width ADDR_WIDTH+1, never exceeds depth.
  - Pointers are ADDR_WIDTH wide and wrap naturally from 15 to 0.
- **Read timing:**
  - 1-cycle latency: on an accepted pop, data_out <= mem[rd_ptr] and valid_out <= 1 at the next edge.
  - Otherwise valid_out <= 0 and data_out holds its value.
- **Flags:**
  - full and empty are decoded from the registered count.
  - pause <= (count_next >= thr_alto); almost_empty <= (count_next <= thr_bajo). Both use count_next, so they are valid in the cycle after the causing push/pop.
  - In INIT: pause=0, almost_empty=1.
- **Error:**
  - error <= 1 for one cycle on: push rejected (full, no pop), or pop rejected (empty).
  - A rejected push is dropped and state is unchanged.
- **Threshold rules:** thr_alto > depth means pause never asserts; thr_alto = 0 means pause is always 1 outside INIT.

Decomposition:
- Shared package (`vc_flow_pkg`) holds:
  - the state encoding: INIT=2'b00, IDLE=2'b01, ACTIVE=2'b10;
  - defaults for DATA_WIDTH and ADDR_WIDTH.
- One natural sub-module: `fifo_mem_dp`, a dual-port register array with synchronous write and synchronous read. It is reused by the other VC and destination FIFOs.
- Control, count and flags live in `vc_fifo_flow`.

Test Plan:
1. **Reset and init load:** reset pulse mid-traffic, then init=1 with umbral_alto=12, umbral_bajo=2 for 2 cycles, then init=0.
   - Expect: empty=1, count=0, almost_empty=1, pause=0, state IDLE.
2. **Fill to pause:** 12 pushes of 0x01..0x0C.
   - Expect: pause rises the cycle after the 12th push.
   - Continue to 16 pushes: full=1. A 17th push gives error=1 for one cycle and count stays 16.
3. **Drain order and latency:** 16 pops from full.
   - Expect: data_out = 0x01..0x10 in order, each one cycle after its pop, valid_out=1.
   - pause falls when count drops to 11; almost_empty rises at count 2; empty=1 at the end.
   - A 17th pop gives error=1 and valid_out=0.
4. **Simultaneous ops:**
   - When full, push and pop together: count stays 16, no error, oldest word is output.
   - When empty, push and pop together: count becomes 1, error=1, valid_out=0.
5. **Wrap-around:** push 10 / pop 10, three times, then push 0x2A.
   - Expect: rd_ptr and wr_ptr wrap past 15. A subsequent pop returns 0x2A, in order.
6. **Init flush:** with count=7, assert init=1 for one cycle with umbral_alto=4.
   - Expect: count=0, empty=1, push and pop ignored during INIT.
   - After INIT, 4 pushes assert pause.
